// File: rtl/mem_top_pkg.sv
// Shared widths, access-size codes and MEM FSM state encoding for the MEM stage.
package mem_top_pkg;

    localparam int REG_BUS_W       = 64;
    localparam int REG_INDEX_BUS_W = 5;
    localparam int DATA_BUS_W      = 64;

    // funct3[1:0] selects the access size, funct3[2] selects zero-extension on loads.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            SZ_D:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replication, misalign detection, load shift/extend.
module mem_align
    import mem_top_pkg::*;
(
    input  logic [1:0]            i_st_size,
    input  logic [2:0]            i_st_off,
    input  logic [DATA_BUS_W-1:0] i_st_data,
    output logic [7:0]            o_wstrb,
    output logic [DATA_BUS_W-1:0] o_wdata,
    output logic                  o_misalign,
    input  logic [2:0]            i_ld_funct3,
    input  logic [2:0]            i_ld_off,
    input  logic [DATA_BUS_W-1:0] i_rdata,
    output logic [DATA_BUS_W-1:0] o_ld_data
);

    logic [DATA_BUS_W-1:0] w_shifted;
    logic                  w_sext;

    always_comb begin
        o_wstrb    = size_mask(i_st_size) << i_st_off;
        o_wdata    = i_st_data;
        o_misalign = 1'b0;
        case (i_st_size)
            SZ_B: o_wdata = {8{i_st_data[7:0]}};
            SZ_H: begin
                o_wdata    = {4{i_st_data[15:0]}};
                o_misalign = i_st_off[0];
            end
            SZ_W: begin
                o_wdata    = {2{i_st_data[31:0]}};
                o_misalign = |i_st_off[1:0];
            end
            default: o_misalign = |i_st_off;
        endcase
    end

    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};
    assign w_sext    = ~i_ld_funct3[2];

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_funct3[1:0])
            SZ_B:    o_ld_data = {{56{w_sext & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_ld_data = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_ld_data = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_top.sv
// MEM stage: data-memory request/response sequencing and the mem2wb pipeline register.
//   state | meaning
//   IDLE  | pass non-memory ops through, launch aligned loads/stores
//   REQ   | request held on the port until accepted
//   RESP  | waiting for the response; load data captured on arrival
module mem_top
    import mem_top_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_top_valid_i,
    input  logic                       mem_top_mem_read_i,
    input  logic                       mem_top_mem_write_i,
    input  logic [2:0]                 mem_top_funct3_i,
    input  logic                       mem_top_ex2mem_rd_en_i,
    input  logic [REG_INDEX_BUS_W-1:0] mem_top_ex2mem_rd_index_i,
    input  logic [REG_BUS_W-1:0]       mem_top_ex2mem_rd_data_i,
    input  logic [DATA_W-1:0]          mem_top_ex2mem_rs2_data_i,
    output logic                       mem_top_dmem_req_valid_o,
    input  logic                       mem_top_dmem_req_ready_i,
    output logic [ADDR_W-1:0]          mem_top_dmem_addr_o,
    output logic                       mem_top_dmem_we_o,
    output logic [7:0]                 mem_top_dmem_wstrb_o,
    output logic [DATA_W-1:0]          mem_top_dmem_wdata_o,
    input  logic                       mem_top_dmem_resp_valid_i,
    input  logic [DATA_W-1:0]          mem_top_dmem_rdata_i,
    output logic                       mem_top_stall_o,
    output logic                       mem_top_misalign_o,
    output logic                       mem_top_mem2wb_valid_o,
    output logic                       mem_top_mem2wb_rd_en_o,
    output logic [REG_INDEX_BUS_W-1:0] mem_top_mem2wb_rd_index_o,
    output logic [REG_BUS_W-1:0]       mem_top_mem2wb_rd_data_o
);

    mem_state_e r_state, w_state_nxt;
    logic       r_done;

    logic [ADDR_W-1:0]          r_addr;
    logic                       r_we;
    logic [7:0]                 r_wstrb;
    logic [DATA_W-1:0]          r_wdata;
    logic [2:0]                 r_funct3;
    logic [2:0]                 r_off;
    logic                       r_is_load;
    logic                       r_rd_en;
    logic [REG_INDEX_BUS_W-1:0] r_rd_index;

    logic                       r_wb_valid;
    logic                       r_wb_rd_en;
    logic [REG_INDEX_BUS_W-1:0] r_wb_rd_index;
    logic [REG_BUS_W-1:0]       r_wb_rd_data;

    logic [ADDR_W-1:0]          w_addr;
    logic                       w_is_mem;
    logic                       w_misalign_raw;
    logic [7:0]                 w_wstrb;
    logic [DATA_W-1:0]          w_wdata;
    logic [DATA_W-1:0]          w_ld_data;
    logic                       w_rd_en_in;
    logic                       w_issue;
    logic                       w_stall;
    logic                       w_req_valid;
    logic                       w_misalign;
    logic                       w_wb_valid;
    logic                       w_wb_rd_en;
    logic [REG_INDEX_BUS_W-1:0] w_wb_rd_index;
    logic [REG_BUS_W-1:0]       w_wb_rd_data;

    assign w_addr     = mem_top_ex2mem_rd_data_i[ADDR_W-1:0];
    assign w_is_mem   = mem_top_mem_read_i | mem_top_mem_write_i;
    assign w_rd_en_in = mem_top_ex2mem_rd_en_i & (|mem_top_ex2mem_rd_index_i);

    mem_align u_align (
        .i_st_size   (mem_top_funct3_i[1:0]),
        .i_st_off    (w_addr[2:0]),
        .i_st_data   (mem_top_ex2mem_rs2_data_i),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_misalign  (w_misalign_raw),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (mem_top_dmem_rdata_i),
        .o_ld_data   (w_ld_data)
    );

    // r_done marks the first IDLE cycle after a completion: ex2mem still holds the
    // finished instruction then, so it is retired as a bubble rather than reissued.
    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_stall       = 1'b0;
        w_req_valid   = 1'b0;
        w_misalign    = 1'b0;
        w_wb_valid    = 1'b0;
        w_wb_rd_en    = 1'b0;
        w_wb_rd_index = '0;
        w_wb_rd_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && mem_top_valid_i && !r_done) begin
                    if (!w_is_mem) begin
                        w_wb_valid    = 1'b1;
                        w_wb_rd_en    = w_rd_en_in;
                        w_wb_rd_index = mem_top_ex2mem_rd_index_i;
                        w_wb_rd_data  = mem_top_ex2mem_rd_data_i;
                    end else if (w_misalign_raw) begin
                        w_misalign    = 1'b1;
                        w_wb_valid    = 1'b1;
                        w_wb_rd_index = mem_top_ex2mem_rd_index_i;
                        w_wb_rd_data  = mem_top_ex2mem_rd_data_i;
                    end else begin
                        w_issue     = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                w_stall     = 1'b1;
                if (mem_top_dmem_req_ready_i) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_stall = 1'b1;
                if (mem_top_dmem_resp_valid_i) begin
                    w_state_nxt   = ST_IDLE;
                    w_wb_valid    = 1'b1;
                    w_wb_rd_en    = r_is_load & r_rd_en;
                    w_wb_rd_index = r_rd_index;
                    w_wb_rd_data  = r_is_load ? w_ld_data : '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_RESP) && mem_top_dmem_resp_valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wstrb    <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_is_load  <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_index <= '0;
        end else if (w_issue) begin
            r_addr     <= {w_addr[ADDR_W-1:3], 3'b000};
            r_we       <= mem_top_mem_write_i;
            r_wstrb    <= mem_top_mem_write_i ? w_wstrb : 8'h00;
            r_wdata    <= w_wdata;
            r_funct3   <= mem_top_funct3_i;
            r_off      <= w_addr[2:0];
            r_is_load  <= ~mem_top_mem_write_i;
            r_rd_en    <= w_rd_en_in;
            r_rd_index <= mem_top_ex2mem_rd_index_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_rd_en    <= 1'b0;
            r_wb_rd_index <= '0;
            r_wb_rd_data  <= '0;
        end else begin
            r_wb_valid    <= w_wb_valid;
            r_wb_rd_en    <= w_wb_rd_en;
            r_wb_rd_index <= w_wb_rd_index;
            r_wb_rd_data  <= w_wb_rd_data;
        end
    end

    assign mem_top_dmem_req_valid_o  = w_req_valid;
    assign mem_top_dmem_addr_o       = r_addr;
    assign mem_top_dmem_we_o         = r_we;
    assign mem_top_dmem_wstrb_o      = r_wstrb;
    assign mem_top_dmem_wdata_o      = r_wdata;
    assign mem_top_stall_o           = w_stall;
    assign mem_top_misalign_o        = w_misalign;
    assign mem_top_mem2wb_valid_o    = r_wb_valid;
    assign mem_top_mem2wb_rd_en_o    = r_wb_rd_en;
    assign mem_top_mem2wb_rd_index_o = r_wb_rd_index;
    assign mem_top_mem2wb_rd_data_o  = r_wb_rd_data;

endmodule

// File: tb/tb_mem_top.sv
// Bench for mem_top: directed vector table, hand sequences, and random ops against a byte-level model.
module tb_mem_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_top_valid_i;
    logic        mem_top_mem_read_i;
    logic        mem_top_mem_write_i;
    logic [2:0]  mem_top_funct3_i;
    logic        mem_top_ex2mem_rd_en_i;
    logic [4:0]  mem_top_ex2mem_rd_index_i;
    logic [63:0] mem_top_ex2mem_rd_data_i;
    logic [63:0] mem_top_ex2mem_rs2_data_i;
    logic        mem_top_dmem_req_valid_o;
    logic        mem_top_dmem_req_ready_i;
    logic [63:0] mem_top_dmem_addr_o;
    logic        mem_top_dmem_we_o;
    logic [7:0]  mem_top_dmem_wstrb_o;
    logic [63:0] mem_top_dmem_wdata_o;
    logic        mem_top_dmem_resp_valid_i;
    logic [63:0] mem_top_dmem_rdata_i;
    logic        mem_top_stall_o;
    logic        mem_top_misalign_o;
    logic        mem_top_mem2wb_valid_o;
    logic        mem_top_mem2wb_rd_en_o;
    logic [4:0]  mem_top_mem2wb_rd_index_o;
    logic [63:0] mem_top_mem2wb_rd_data_o;

    always #5 clk = ~clk;

    mem_top dut (
        .clk                       (clk),
        .rst                       (rst),
        .mem_top_valid_i           (mem_top_valid_i),
        .mem_top_mem_read_i        (mem_top_mem_read_i),
        .mem_top_mem_write_i       (mem_top_mem_write_i),
        .mem_top_funct3_i          (mem_top_funct3_i),
        .mem_top_ex2mem_rd_en_i    (mem_top_ex2mem_rd_en_i),
        .mem_top_ex2mem_rd_index_i (mem_top_ex2mem_rd_index_i),
        .mem_top_ex2mem_rd_data_i  (mem_top_ex2mem_rd_data_i),
        .mem_top_ex2mem_rs2_data_i (mem_top_ex2mem_rs2_data_i),
        .mem_top_dmem_req_valid_o  (mem_top_dmem_req_valid_o),
        .mem_top_dmem_req_ready_i  (mem_top_dmem_req_ready_i),
        .mem_top_dmem_addr_o       (mem_top_dmem_addr_o),
        .mem_top_dmem_we_o         (mem_top_dmem_we_o),
        .mem_top_dmem_wstrb_o      (mem_top_dmem_wstrb_o),
        .mem_top_dmem_wdata_o      (mem_top_dmem_wdata_o),
        .mem_top_dmem_resp_valid_i (mem_top_dmem_resp_valid_i),
        .mem_top_dmem_rdata_i      (mem_top_dmem_rdata_i),
        .mem_top_stall_o           (mem_top_stall_o),
        .mem_top_misalign_o        (mem_top_misalign_o),
        .mem_top_mem2wb_valid_o    (mem_top_mem2wb_valid_o),
        .mem_top_mem2wb_rd_en_o    (mem_top_mem2wb_rd_en_o),
        .mem_top_mem2wb_rd_index_o (mem_top_mem2wb_rd_index_o),
        .mem_top_mem2wb_rd_data_o  (mem_top_mem2wb_rd_data_o)
    );

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic        rd_en;
        logic [4:0]  idx;
        logic [63:0] addr;
        logic [63:0] rs2;
        logic [63:0] rdata;
        int          rdy;
        int          rsp;
        logic        e_mis;
        logic        e_rd_en;
        logic [63:0] e_data;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic valid, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic rd_en, input logic [4:0] idx,
                                 input logic [63:0] addr, input logic [63:0] rs2,
                                 input logic [63:0] rdata, input int rdy, input int rsp,
                                 input logic e_mis, input logic e_rd_en, input logic [63:0] e_data,
                                 input logic [7:0] e_wstrb, input logic [63:0] e_wdata);
        vec_t v;
        v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3; v.rd_en = rd_en; v.idx = idx;
        v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.rdy = rdy; v.rsp = rsp;
        v.e_mis = e_mis; v.e_rd_en = e_rd_en; v.e_data = e_data;
        v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model: access size in bytes, byte offset arithmetic.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] fmask(input int n);
        return (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int          n = nbytes(f3);
        logic [63:0] m = fmask(n);
        logic [63:0] v = (rdata >> (8 * int'(addr[2:0]))) & m;
        if (!f3[2] && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input logic [63:0] addr);
        int s = ((1 << nbytes(f3)) - 1) << int'(addr[2:0]);
        return s[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] rs2);
        int          n   = nbytes(f3);
        logic [63:0] low = rs2 & fmask(n);
        logic [63:0] r   = '0;
        for (int k = 0; k < 8 / n; k++) r = r | (low << (8 * n * k));
        return r;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [63:0] addr);
        return (int'(addr[2:0]) % nbytes(f3)) != 0;
    endfunction

    // Starts 1 time unit after a rising edge; returns at the same phase.
    task automatic run_op(input vec_t v, input bit resp_in_req);
        bit          is_mem = v.valid && (v.rd || v.wr);
        bit          is_ld  = is_mem && !v.wr;
        int          stalls = 0;
        logic [63:0] e_addr = v.addr & ~64'h7;
        mem_top_valid_i           = v.valid;
        mem_top_mem_read_i        = v.rd;
        mem_top_mem_write_i       = v.wr;
        mem_top_funct3_i          = v.f3;
        mem_top_ex2mem_rd_en_i    = v.rd_en;
        mem_top_ex2mem_rd_index_i = v.idx;
        mem_top_ex2mem_rd_data_i  = v.addr;
        mem_top_ex2mem_rs2_data_i = v.rs2;
        mem_top_dmem_req_ready_i  = 1'b0;
        mem_top_dmem_resp_valid_i = 1'b0;
        mem_top_dmem_rdata_i      = {$urandom, $urandom};
        #3;
        chk("misalign", mem_top_misalign_o, is_mem && v.e_mis);
        if (!is_mem || v.e_mis) begin
            chk("stall_flow", mem_top_stall_o, 0);
            chk("req_valid_flow", mem_top_dmem_req_valid_o, 0);
            @(posedge clk); #1;
            chk("wb_valid", mem_top_mem2wb_valid_o, v.valid);
            if (v.valid) begin
                chk("wb_rd_en", mem_top_mem2wb_rd_en_o, v.e_rd_en);
                chk("wb_index", mem_top_mem2wb_rd_index_o, v.idx);
                if (!is_mem) chk("wb_data", mem_top_mem2wb_rd_data_o, v.e_data);
            end
            return;
        end
        chk("req_valid_issue", mem_top_dmem_req_valid_o, 0);
        if (mem_top_stall_o) stalls++;
        @(posedge clk); #1;
        chk("wb_bubble_issue", mem_top_mem2wb_valid_o, 0);
        for (int k = 0; k <= v.rdy; k++) begin
            mem_top_dmem_req_ready_i = (k == v.rdy);
            if (resp_in_req && k == v.rdy) begin
                mem_top_dmem_resp_valid_i = 1'b1;
                mem_top_dmem_rdata_i      = ~v.rdata;
            end
            #3;
            if (mem_top_stall_o) stalls++;
            chk("req_valid", mem_top_dmem_req_valid_o, 1);
            chk("req_addr", mem_top_dmem_addr_o, e_addr);
            chk("req_we", mem_top_dmem_we_o, v.wr);
            if (v.wr) begin
                chk("req_wstrb", mem_top_dmem_wstrb_o, v.e_wstrb);
                chk("req_wdata", mem_top_dmem_wdata_o, v.e_wdata);
            end
            @(posedge clk); #1;
            mem_top_dmem_req_ready_i  = 1'b0;
            mem_top_dmem_resp_valid_i = 1'b0;
            chk("wb_bubble_req", mem_top_mem2wb_valid_o, 0);
        end
        for (int k = 0; k <= v.rsp; k++) begin
            mem_top_dmem_resp_valid_i = (k == v.rsp);
            mem_top_dmem_rdata_i      = (k == v.rsp) ? v.rdata : {$urandom, $urandom};
            #3;
            if (mem_top_stall_o) stalls++;
            chk("req_valid_resp", mem_top_dmem_req_valid_o, 0);
            @(posedge clk); #1;
            mem_top_dmem_resp_valid_i = 1'b0;
            if (k < v.rsp) chk("wb_bubble_resp", mem_top_mem2wb_valid_o, 0);
        end
        chk("wb_valid_mem", mem_top_mem2wb_valid_o, 1);
        chk("wb_rd_en_mem", mem_top_mem2wb_rd_en_o, v.e_rd_en);
        if (is_ld) begin
            chk("wb_index_ld", mem_top_mem2wb_rd_index_o, v.idx);
            chk("wb_data_ld", mem_top_mem2wb_rd_data_o, v.e_data);
        end
        #3;
        chk("stall_released", mem_top_stall_o, 0);
        chk("no_reissue", mem_top_dmem_req_valid_o, 0);
        chk("stall_cycles", stalls, 3 + v.rdy + v.rsp);
        @(posedge clk); #1;
        chk("wb_bubble_after", mem_top_mem2wb_valid_o, 0);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_top_valid_i = 0; mem_top_mem_read_i = 0; mem_top_mem_write_i = 0;
        mem_top_funct3_i = 0; mem_top_ex2mem_rd_en_i = 0; mem_top_ex2mem_rd_index_i = 0;
        mem_top_ex2mem_rd_data_i = 0; mem_top_ex2mem_rs2_data_i = 0;
        mem_top_dmem_req_ready_i = 0; mem_top_dmem_resp_valid_i = 0; mem_top_dmem_rdata_i = 0;
        #1;
        chk("rst_stall", mem_top_stall_o, 0);
        chk("rst_req_valid", mem_top_dmem_req_valid_o, 0);
        chk("rst_misalign", mem_top_misalign_o, 0);
        chk("rst_wb_valid", mem_top_mem2wb_valid_o, 0);
        chk("rst_wb_rd_en", mem_top_mem2wb_rd_en_o, 0);
        chk("rst_wb_index", mem_top_mem2wb_rd_index_o, 0);
        chk("rst_wb_data", mem_top_mem2wb_rd_data_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //         v  rd wr f3 en idx addr            rs2                      rdata                    rdy rsp mis ren e_data                   wstrb  wdata
        tbl.push_back(mkv(1, 0, 0, 3'd0, 1, 5,  64'h1234, 0, 0, 0, 0, 0, 1, 64'h1234, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd3, 1, 10, 64'h1000, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd0, 1, 11, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd4, 1, 11, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 1, 64'h80, 0, 0));
        tbl.push_back(mkv(1, 0, 1, 3'd1, 1, 12, 64'h2006, 64'hABCD, 0, 1, 0, 0, 0, 0, 8'hC0, 64'hABCD_ABCD_ABCD_ABCD));
        tbl.push_back(mkv(1, 1, 0, 3'd2, 1, 13, 64'h3002, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 3'd0, 1, 0,  64'h55AA, 0, 0, 0, 0, 0, 0, 64'h55AA, 0, 0));
        tbl.push_back(mkv(1, 0, 1, 3'd3, 0, 0,  64'h4000, 64'h0123_4567_89AB_CDEF, 0, 5, 2, 0, 0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF));
        tbl.push_back(mkv(1, 1, 0, 3'd1, 1, 14, 64'h5002, 0, 64'h1111_2222_8001_3333, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_8001, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd6, 1, 15, 64'h6004, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 1, 64'h0000_0000_8765_4321, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd2, 1, 15, 64'h6004, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 1, 64'hFFFF_FFFF_8765_4321, 0, 0));
        tbl.push_back(mkv(1, 0, 1, 3'd0, 1, 16, 64'h7005, 64'h1234_565A, 0, 0, 0, 0, 0, 0, 8'h20, 64'h5A5A_5A5A_5A5A_5A5A));
        tbl.push_back(mkv(1, 1, 0, 3'd3, 1, 17, 64'h8004, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 3'd0, 1, 18, 64'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd3, 1, 0,  64'h1008, 0, 64'hFFFF, 0, 0, 0, 0, 64'hFFFF, 0, 0));
        tbl.push_back(mkv(1, 1, 0, 3'd5, 1, 19, 64'h100E, 0, 64'hF00D_0000_0000_0000, 2, 3, 0, 1, 64'hF00D, 0, 0));

        foreach (tbl[i]) run_op(tbl[i], 1'b0);

        // Response offered together with ready must be ignored.
        run_op(mkv(1, 1, 0, 3'd3, 1, 9, 64'hA010, 0, 64'h0BAD_F00D_1234_5678, 0, 0, 0, 1, 64'h0BAD_F00D_1234_5678, 0, 0), 1'b1);
        run_op(mkv(1, 1, 0, 3'd1, 1, 9, 64'hA012, 0, 64'h0000_0000_7FFF_0000, 2, 1, 0, 1, 64'h7FFF, 0, 0), 1'b1);

        // Asynchronous reset while waiting in RESP.
        mem_top_valid_i = 1; mem_top_mem_read_i = 0; mem_top_mem_write_i = 1;
        mem_top_funct3_i = 3'd3; mem_top_ex2mem_rd_en_i = 0; mem_top_ex2mem_rd_index_i = 0;
        mem_top_ex2mem_rd_data_i = 64'h9008; mem_top_ex2mem_rs2_data_i = 64'h0F0E_0D0C_0B0A_0908;
        @(posedge clk); #1;
        mem_top_dmem_req_ready_i = 1;
        @(posedge clk); #1;
        mem_top_dmem_req_ready_i = 0;
        #2;
        chk("pre_rst_stall", mem_top_stall_o, 1);
        chk("pre_rst_we", mem_top_dmem_we_o, 1);
        chk("pre_rst_addr", mem_top_dmem_addr_o, 64'h9008);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", mem_top_stall_o, 0);
        chk("mid_rst_req_valid", mem_top_dmem_req_valid_o, 0);
        chk("mid_rst_misalign", mem_top_misalign_o, 0);
        chk("mid_rst_addr", mem_top_dmem_addr_o, 0);
        chk("mid_rst_we", mem_top_dmem_we_o, 0);
        chk("mid_rst_wstrb", mem_top_dmem_wstrb_o, 0);
        chk("mid_rst_wdata", mem_top_dmem_wdata_o, 0);
        chk("mid_rst_wb_valid", mem_top_mem2wb_valid_o, 0);
        chk("mid_rst_wb_data", mem_top_mem2wb_rd_data_o, 0);
        mem_top_valid_i = 0; mem_top_mem_write_i = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(mkv(1, 0, 0, 3'd0, 1, 21, 64'hC0FFEE, 0, 0, 0, 0, 0, 1, 64'hC0FFEE, 0, 0), 1'b0);

        for (int t = 0; t < 60; t++) begin
            vec_t v;
            int   kind;
            int   n;
            bit   is_mem;
            kind    = $urandom_range(0, 9);
            v.valid = (kind != 0);
            v.rd    = (kind >= 4 && kind <= 6);
            v.wr    = (kind >= 7);
            if (v.rd)      v.f3 = 3'($urandom_range(0, 6));
            else if (v.wr) v.f3 = 3'($urandom_range(0, 3));
            else           v.f3 = 3'($urandom_range(0, 7));
            v.rd_en = ($urandom_range(0, 3) != 0);
            v.idx   = 5'($urandom_range(0, 31));
            n       = nbytes(v.f3);
            v.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~(64'(n) - 64'd1);
            v.rs2   = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.rdy   = $urandom_range(0, 3);
            v.rsp   = $urandom_range(0, 3);
            is_mem  = v.valid && (v.rd || v.wr);
            v.e_mis   = is_mem && model_mis(v.f3, v.addr);
            v.e_rd_en = v.rd_en && (v.idx != 0) && (!is_mem || (v.rd && !v.e_mis));
            v.e_data  = is_mem ? model_load(v.f3, v.addr, v.rdata) : v.addr;
            v.e_wstrb = model_wstrb(v.f3, v.addr);
            v.e_wdata = model_wdata(v.f3, v.rs2);
            run_op(v, $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
